sequence_generator: RTL and testbench

Enumerates every gate sequence from length 1 up to MAX_LENGTH over a gate alphabet of NUM_GATES, in odometer order with index 0 varying fastest. It presents each sequence to the Sequence Multiplier one item at a time, from the highest index down to index 0, over the ready/first/available handshake. After each completed sequence it restarts from the highest digit that changed, so unchanged higher items are never re-presented. It sits directly upstream of the Sequence Multiplier; the Solution and Duplicate Checkers can stall it through `hold`.

---
 rtl/sequence_generator_pkg.sv | 18 +
 rtl/sequence_generator_gate_odometer.sv | 69 ++++++
 rtl/sequence_generator.sv | 134 +++++++++++++
 tb/tb_sequence_generator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sequence_generator_pkg.sv
// Shared defaults and FSM state type for the gate-sequence enumerator
// and the downstream sequence multiplier.
package sequence_generator_pkg;

    localparam int DEF_SEQ_INDEX_BITS = 5;
    localparam int DEF_GATE_BITS      = 5;
    localparam int DEF_NUM_GATES      = 6;
    localparam int DEF_MAX_LENGTH     = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_AVAIL,
        ST_ADVANCE,
        ST_FINISHED
    } gen_state_e;

endpackage

// File: rtl/sequence_generator_gate_odometer.sv
// Base-NUM_GATES digit counter over the live length, reporting the highest
// digit an increment would change and whether it carries out of the top digit.
module sequence_generator_gate_odometer #(
    parameter int SEQ_INDEX_BITS = 5,
    parameter int GATE_BITS      = 5,
    parameter int NUM_GATES      = 6,
    parameter int MAX_LENGTH     = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear_i,
    input  logic                      incr_i,
    input  logic [SEQ_INDEX_BITS:0]   length_i,
    input  logic [SEQ_INDEX_BITS-1:0] sel_i,
    output logic [GATE_BITS-1:0]      gate_o,
    output logic [SEQ_INDEX_BITS-1:0] restart_o,
    output logic                      overflow_o
);

    logic [GATE_BITS-1:0] digit_q [MAX_LENGTH];
    logic [GATE_BITS-1:0] digit_d [MAX_LENGTH];
    logic [MAX_LENGTH:0]   carry;
    logic [MAX_LENGTH-1:0] live;
    logic [MAX_LENGTH-1:0] wrap;
    logic [MAX_LENGTH-1:0] changed;
    logic [MAX_LENGTH-1:0] ovf_hit;

    assign carry[0] = 1'b1;

    // Carry ripples only through live digits; a digit changes iff a carry reaches it.
    for (genvar gi = 0; gi < MAX_LENGTH; gi++) begin : g_digit
        assign live[gi]      = ((SEQ_INDEX_BITS+1)'(gi) < length_i);
        assign wrap[gi]      = (digit_q[gi] == GATE_BITS'(NUM_GATES - 1));
        assign changed[gi]   = carry[gi] & live[gi];
        assign carry[gi+1]   = changed[gi] & wrap[gi];
        assign ovf_hit[gi]   = carry[gi+1] & (length_i == (SEQ_INDEX_BITS+1)'(gi + 1));
        assign digit_d[gi]   = clear_i                  ? '0 :
                               (incr_i && changed[gi])  ? (wrap[gi] ? '0 : digit_q[gi] + 1'b1) :
                               digit_q[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                digit_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_LENGTH; i++) begin
                digit_q[i] <= digit_d[i];
            end
        end
    end

    always_comb begin
        restart_o = '0;
        gate_o    = '0;
        for (int i = 0; i < MAX_LENGTH; i++) begin
            if (changed[i]) begin
                restart_o = SEQ_INDEX_BITS'(i);
            end
            if (sel_i == SEQ_INDEX_BITS'(i)) begin
                gate_o = digit_q[i];
            end
        end
    end

    assign overflow_o = |ovf_hit;

endmodule

// File: rtl/sequence_generator.sv
// Enumerates all gate sequences of length 1..MAX_LENGTH and presents each one,
// highest index first, to the sequence multiplier over a ready/available handshake.
module sequence_generator
    import sequence_generator_pkg::*;
#(
    parameter int SEQ_INDEX_BITS = DEF_SEQ_INDEX_BITS,
    parameter int GATE_BITS      = DEF_GATE_BITS,
    parameter int NUM_GATES      = DEF_NUM_GATES,
    parameter int MAX_LENGTH     = DEF_MAX_LENGTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      hold,
    output logic [SEQ_INDEX_BITS-1:0] seq_index,
    output logic [GATE_BITS-1:0]      seq_gate,
    output logic                      ready,
    output logic                      first,
    input  logic                      available,
    output logic [SEQ_INDEX_BITS:0]   seq_length,
    output logic [31:0]               seq_count,
    output logic                      busy,
    output logic                      finished
);

    localparam logic [SEQ_INDEX_BITS:0] MAX_LEN_L = (SEQ_INDEX_BITS+1)'(MAX_LENGTH);

    gen_state_e                state_q, state_d;
    logic [SEQ_INDEX_BITS-1:0] index_q, index_d;
    logic [SEQ_INDEX_BITS:0]   length_q, length_d;
    logic [31:0]               count_q, count_d;
    logic                      odo_clear;
    logic                      odo_incr;
    logic [SEQ_INDEX_BITS-1:0] restart_idx;
    logic                      overflow;

    sequence_generator_gate_odometer #(
        .SEQ_INDEX_BITS (SEQ_INDEX_BITS),
        .GATE_BITS      (GATE_BITS),
        .NUM_GATES      (NUM_GATES),
        .MAX_LENGTH     (MAX_LENGTH)
    ) u_odometer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (odo_clear),
        .incr_i     (odo_incr),
        .length_i   (length_q),
        .sel_i      (index_q),
        .gate_o     (seq_gate),
        .restart_o  (restart_idx),
        .overflow_o (overflow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            index_q  <= '0;
            length_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            length_q <= length_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        length_d  = length_q;
        count_d   = count_q;
        odo_clear = 1'b0;
        odo_incr  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FINISHED: begin
                    if (start) begin
                        odo_clear = 1'b1;
                        length_d  = (SEQ_INDEX_BITS+1)'(1);
                        index_d   = '0;
                        count_d   = '0;
                        state_d   = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!hold) begin
                        state_d = ST_WAIT_AVAIL;
                    end
                end
                ST_WAIT_AVAIL: begin
                    if (available) begin
                        if (index_q != '0) begin
                            index_d = index_q - 1'b1;
                            state_d = ST_ISSUE;
                        end else begin
                            count_d = count_q + 32'd1;
                            state_d = ST_ADVANCE;
                        end
                    end
                end
                ST_ADVANCE: begin
                    if (!overflow) begin
                        odo_incr = 1'b1;
                        index_d  = restart_idx;
                        state_d  = ST_ISSUE;
                    end else if (length_q < MAX_LEN_L) begin
                        // Next length starts from all-zero digits, top item first.
                        odo_clear = 1'b1;
                        length_d  = length_q + 1'b1;
                        index_d   = length_q[SEQ_INDEX_BITS-1:0];
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_FINISHED;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ready      = (state_q == ST_ISSUE) && !hold && !stop;
    assign first      = ((state_q == ST_ISSUE) || (state_q == ST_WAIT_AVAIL)) &&
                        ({1'b0, index_q} == (length_q - (SEQ_INDEX_BITS+1)'(1)));
    assign seq_index  = index_q;
    assign seq_length = length_q;
    assign seq_count  = count_q;
    assign busy       = (state_q != ST_IDLE) && (state_q != ST_FINISHED);
    assign finished   = (state_q == ST_FINISHED);

endmodule

// File: tb/tb_sequence_generator.sv
// Directed bench: a 3-gate/length-2 instance checked item by item against a
// hand-written list, and a 2-gate/length-5 instance checked on totals.
module tb_sequence_generator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start_a = 0, stop_a = 0, hold_a = 0, avail_a = 0;
    logic [4:0]  idx_a, gate_a;
    logic        ready_a, first_a, busy_a, fin_a;
    logic [5:0]  len_a;
    logic [31:0] cnt_a;

    logic        start_b = 0, stop_b = 0, hold_b = 0, avail_b = 0;
    logic [4:0]  idx_b, gate_b;
    logic        ready_b, first_b, busy_b, fin_b;
    logic [5:0]  len_b;
    logic [31:0] cnt_b;

    sequence_generator #(.SEQ_INDEX_BITS(5), .GATE_BITS(5), .NUM_GATES(3), .MAX_LENGTH(2)) dut_a (
        .clk(clk), .reset(rst), .start(start_a), .stop(stop_a), .hold(hold_a),
        .seq_index(idx_a), .seq_gate(gate_a), .ready(ready_a), .first(first_a),
        .available(avail_a), .seq_length(len_a), .seq_count(cnt_a),
        .busy(busy_a), .finished(fin_a)
    );

    sequence_generator #(.SEQ_INDEX_BITS(5), .GATE_BITS(5), .NUM_GATES(2), .MAX_LENGTH(5)) dut_b (
        .clk(clk), .reset(rst), .start(start_b), .stop(stop_b), .hold(hold_b),
        .seq_index(idx_b), .seq_gate(gate_b), .ready(ready_b), .first(first_b),
        .available(avail_b), .seq_length(len_b), .seq_count(cnt_b),
        .busy(busy_b), .finished(fin_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input int i, input int g, input bit f);
        return {5'(i), 5'(g), f};
    endfunction

    logic [10:0] exp_a [15];
    int items_a   = 0;
    bit auto_a    = 0;
    bit hold_test = 0;
    bit auto_b    = 0;
    int readies_b = 0;

    // Item monitor: every ready on instance A is compared with the expected list.
    initial forever begin
        @(negedge clk);
        if (ready_a) begin
            $display("A item %0d: index=%0d gate=%0d first=%0d len=%0d", items_a, idx_a, gate_a, first_a, len_a);
            check("a_ready_while_hold", 32'(hold_a), 0);
            if (items_a < 15)
                check($sformatf("a_item%0d", items_a), 32'({idx_a, gate_a, first_a}), 32'(exp_a[items_a]));
            else
                check("a_item_overflow", items_a + 1, 15);
            items_a++;
        end
    end

    // Multiplier stand-in for A: available one cycle after each ready.
    initial forever begin
        @(negedge clk);
        if (auto_a && ready_a) begin
            if (hold_test && idx_a == 5'd1 && gate_a == 5'd1) begin
                @(posedge clk); #1 hold_a = 1; avail_a = 1;
                @(posedge clk); #1 avail_a = 0;
                @(posedge clk); @(posedge clk); #1;
                check("a_hold_ready", 32'(ready_a), 0);
                check("a_hold_index", 32'(idx_a), 0);
                check("a_hold_busy", 32'(busy_a), 1);
                @(posedge clk); @(posedge clk); #1 hold_a = 0;
            end else begin
                @(posedge clk); #1 avail_a = 1;
                @(posedge clk); #1 avail_a = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (auto_b && ready_b) begin
            readies_b++;
            @(posedge clk); #1 avail_b = 1;
            @(posedge clk); #1 avail_b = 0;
        end
    end

    task automatic check_reset_a(input string pfx);
        check({pfx, "_index"}, 32'(idx_a), 0);
        check({pfx, "_gate"}, 32'(gate_a), 0);
        check({pfx, "_ready"}, 32'(ready_a), 0);
        check({pfx, "_first"}, 32'(first_a), 0);
        check({pfx, "_length"}, 32'(len_a), 0);
        check({pfx, "_count"}, cnt_a, 0);
        check({pfx, "_busy"}, 32'(busy_a), 0);
        check({pfx, "_finished"}, 32'(fin_a), 0);
    endtask

    task automatic wait_fin_a(input int lim, input string tag);
        int c = 0;
        while (!fin_a && c < lim) begin
            @(posedge clk); #1;
            c++;
        end
        check(tag, 32'(fin_a), 1);
    endtask

    task automatic wait_ready_a(input int lim, input string tag);
        int c = 0;
        @(negedge clk);
        while (!ready_a && c < lim) begin
            @(negedge clk);
            c++;
        end
        check(tag, 32'(ready_a), 1);
    endtask

    task automatic pulse_start_a();
        start_a = 1;
        @(posedge clk); #1 start_a = 0;
    endtask

    initial begin
        exp_a[0]  = mk(0, 0, 1); exp_a[1]  = mk(0, 1, 1); exp_a[2]  = mk(0, 2, 1);
        exp_a[3]  = mk(1, 0, 1); exp_a[4]  = mk(0, 0, 0); exp_a[5]  = mk(0, 1, 0);
        exp_a[6]  = mk(0, 2, 0); exp_a[7]  = mk(1, 1, 1); exp_a[8]  = mk(0, 0, 0);
        exp_a[9]  = mk(0, 1, 0); exp_a[10] = mk(0, 2, 0); exp_a[11] = mk(1, 2, 1);
        exp_a[12] = mk(0, 0, 0); exp_a[13] = mk(0, 1, 0); exp_a[14] = mk(0, 2, 0);

        repeat (2) @(posedge clk);
        #1 check_reset_a("rst");
        rst = 0;
        @(posedge clk); #1;

        // Spurious available while idle
        avail_a = 1;
        @(posedge clk); #1 avail_a = 0;
        check("idle_avail_busy", 32'(busy_a), 0);
        check("idle_avail_length", 32'(len_a), 0);

        // Full enumeration with immediate responses
        items_a = 0; auto_a = 1;
        pulse_start_a();
        check("run1_first_ready", 32'(ready_a), 1);
        check("run1_length", 32'(len_a), 1);
        wait_fin_a(200, "run1_finish");
        check("run1_count", cnt_a, 12);
        check("run1_items", items_a, 15);
        check("run1_busy", 32'(busy_a), 0);
        repeat (3) @(posedge clk);
        #1 check("run1_finished_held", 32'(fin_a), 1);

        // Same enumeration with a 5-cycle hold around item (1,1)
        items_a = 0; hold_test = 1;
        pulse_start_a();
        wait_fin_a(200, "run2_finish");
        check("run2_count", cnt_a, 12);
        check("run2_items", items_a, 15);
        hold_test = 0;

        // Manual handshake; stop during WAIT_AVAIL of the first length-2 item
        auto_a = 0; items_a = 0;
        pulse_start_a();
        for (int k = 0; k < 4; k++) begin
            wait_ready_a(20, "run3_ready");
            if (k < 3) begin
                @(posedge clk); #1 avail_a = 1;
                @(posedge clk); #1 avail_a = 0;
            end
        end
        @(posedge clk); #1 stop_a = 1;
        @(posedge clk); #1 stop_a = 0;
        check("stop_busy", 32'(busy_a), 0);
        check("stop_ready", 32'(ready_a), 0);
        check("stop_finished", 32'(fin_a), 0);
        check("stop_count", cnt_a, 3);
        avail_a = 1;
        @(posedge clk); #1 avail_a = 0;
        @(posedge clk); #1;
        check("late_avail_busy", 32'(busy_a), 0);
        check("late_avail_count", cnt_a, 3);

        items_a = 0;
        pulse_start_a();
        check("restart_length", 32'(len_a), 1);
        check("restart_index", 32'(idx_a), 0);
        check("restart_gate", 32'(gate_a), 0);
        check("restart_ready", 32'(ready_a), 1);
        check("restart_first", 32'(first_a), 1);
        check("restart_count", cnt_a, 0);

        // available held over WAIT_AVAIL, ADVANCE and the next ISSUE
        @(posedge clk); #1 avail_a = 1;
        repeat (3) @(posedge clk);
        #1 avail_a = 0;
        repeat (3) @(posedge clk);
        #1;
        check("dbl_avail_count", cnt_a, 1);
        check("dbl_avail_items", items_a, 2);
        check("dbl_avail_gate", 32'(gate_a), 1);
        check("dbl_avail_ready", 32'(ready_a), 0);
        check("dbl_avail_busy", 32'(busy_a), 1);

        // Park in ISSUE with hold, then assert reset between edges
        hold_a = 1; avail_a = 1;
        @(posedge clk); #1 avail_a = 0;
        @(posedge clk); @(posedge clk); #1;
        check("park_ready", 32'(ready_a), 0);
        check("park_gate", 32'(gate_a), 2);
        check("park_busy", 32'(busy_a), 1);
        #2 rst = 1;
        #1 check_reset_a("async_rst");
        @(posedge clk); #1 rst = 0; hold_a = 0;

        // 2 gates, length 5: 62 sequences, 114 items; a start mid-run is ignored
        auto_b = 1; readies_b = 0;
        start_b = 1;
        @(posedge clk); #1 start_b = 0;
        repeat (50) @(posedge clk);
        #1 start_b = 1;
        @(posedge clk); #1 start_b = 0;
        begin
            int c = 0;
            while (!fin_b && c < 3000) begin
                @(posedge clk); #1;
                c++;
            end
        end
        check("b_finish", 32'(fin_b), 1);
        check("b_count", cnt_b, 62);
        check("b_readies", readies_b, 114);
        check("b_length", 32'(len_b), 5);
        check("b_busy", 32'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
